// File: rtl/gw2a_ddr_rdcap.sv
// gw2a_ddr_rdcap: read-data capture and BL8 burst assembly for the GW2A DDR3 PHY.
// Each read command travels through a 16-stage {valid, tag} delay line. When it reaches
// stage 0, a 4-state capture FSM samples the IOB Q0/Q1 pairs on four consecutive PCLK
// cycles. The assembled burst goes into a 2-entry valid/ready output FIFO.
// Optional build macro GW2A_RDCAP_CALIB_EN adds a fixed-pattern calibration comparator.
module gw2a_ddr_rdcap #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAGW  = 4
) (
  input  logic               PCLK,
  input  logic               RESET,
  input  logic               rd_req_i,
  input  logic [TAGW-1:0]    rd_tag_i,
  input  logic [3:0]         delay_i,
  input  logic [WIDTH-1:0]   dq_q0_i,
  input  logic [WIDTH-1:0]   dq_q1_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [8*WIDTH-1:0] rd_data_o,
  output logic [TAGW-1:0]    rd_tag_o,
  output logic               overflow_o,
  output logic               collide_o,
  output logic               calib_pass_o,
  output logic               calib_fail_o
);

  localparam int unsigned Stages = 16;

  typedef enum logic [2:0] {StIdle, StCap0, StCap1, StCap2, StCap3} state_e;

  // ---------------------------------------------------------------------------
  // Delay line
  // ---------------------------------------------------------------------------
  // A request with latency D must be at stage 0 in cycle t+D-1. The FSM then enters
  // CAP0 in cycle t+D. So the request is overlaid combinationally at index D-1.
  // For D=1 the request reaches stage 0 in the same cycle it is issued.
  logic [3:0]        w_wr_idx;
  logic [Stages-1:0] r_stg_vld;
  logic [Stages-1:0] w_stg_vld;
  logic [TAGW-1:0]   r_stg_tag [Stages];
  logic [TAGW-1:0]   w_stg_tag [Stages];
  logic              w_same_stage;
  logic              w_start;

  // Clamp D=0 to 1 and convert the latency to a stage index.
  always_comb begin
    w_wr_idx = (delay_i == 4'd0) ? 4'd0 : delay_i - 4'd1;
  end

  // Overlay the incoming request; a later write to an occupied stage wins.
  always_comb begin
    w_stg_vld    = r_stg_vld;
    w_stg_tag    = r_stg_tag;
    w_same_stage = 1'b0;
    if (rd_req_i) begin
      w_same_stage        = r_stg_vld[w_wr_idx];
      w_stg_vld[w_wr_idx] = 1'b1;
      w_stg_tag[w_wr_idx] = rd_tag_i;
    end
  end

  assign w_start = w_stg_vld[0];

  // Shift every stage one step toward stage 0 each cycle.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_stg_vld <= '0;
      for (int i = 0; i < Stages; i++) r_stg_tag[i] <= '0;
    end else begin
      r_stg_vld <= {1'b0, w_stg_vld[Stages-1:1]};
      for (int i = 0; i < Stages - 1; i++) r_stg_tag[i] <= w_stg_tag[i+1];
      r_stg_tag[Stages-1] <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e              r_state;
  state_e              w_state_d;
  logic                w_collide;
  logic                w_push;
  logic [6*WIDTH-1:0]  r_beats;
  logic [TAGW-1:0]     r_cap_tag;
  logic [8*WIDTH-1:0]  w_burst;

  // State register.
  always_ff @(posedge PCLK) begin
    if (RESET) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next state, collision detect and push strobe.
  always_comb begin
    w_state_d = r_state;
    w_collide = 1'b0;
    w_push    = 1'b0;
    unique case (r_state)
      StIdle: if (w_start) w_state_d = StCap0;
      StCap0: begin
        w_state_d = StCap1;
        if (w_start) begin
          w_collide = 1'b1;
          w_state_d = StCap0;
        end
      end
      StCap1: begin
        w_state_d = StCap2;
        if (w_start) begin
          w_collide = 1'b1;
          w_state_d = StCap0;
        end
      end
      StCap2: begin
        w_state_d = StCap3;
        if (w_start) begin
          w_collide = 1'b1;
          w_state_d = StCap0;
        end
      end
      StCap3: begin
        w_push    = 1'b1;
        w_state_d = w_start ? StCap0 : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Register pairs 0..2; pair 3 is taken straight from the IOB when the burst is pushed.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_beats   <= '0;
      r_cap_tag <= '0;
    end else begin
      if (w_start) r_cap_tag <= w_stg_tag[0];
      unique case (r_state)
        StCap0: r_beats[0*WIDTH +: 2*WIDTH] <= {dq_q1_i, dq_q0_i};
        StCap1: r_beats[2*WIDTH +: 2*WIDTH] <= {dq_q1_i, dq_q0_i};
        StCap2: r_beats[4*WIDTH +: 2*WIDTH] <= {dq_q1_i, dq_q0_i};
        default: ;
      endcase
    end
  end

  assign w_burst = {dq_q1_i, dq_q0_i, r_beats};

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [8*WIDTH-1:0] r_mem_data [2];
  logic [TAGW-1:0]    r_mem_tag  [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_pop;
  logic               w_full;
  logic               w_push_ok;
  logic               w_overflow;

  // When full, a simultaneous pop frees the head slot, which is the slot the push writes.
  always_comb begin
    w_full     = (r_count == 2'd2);
    w_pop      = (r_count != 2'd0) && rd_ready_i;
    w_push_ok  = w_push && (!w_full || w_pop);
    w_overflow = w_push && w_full && !w_pop;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_tag[0]  <= '0;
      r_mem_tag[1]  <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem_data[r_wr_ptr] <= w_burst;
        r_mem_tag[r_wr_ptr]  <= r_cap_tag;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-FIFO presentation.
  always_comb begin
    rd_valid_o = (r_count != 2'd0);
    rd_data_o  = r_mem_data[r_rd_ptr];
    rd_tag_o   = r_mem_tag[r_rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic r_overflow;
  logic r_collide;

  // Flags set on event and clear only on reset.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_overflow <= 1'b0;
      r_collide  <= 1'b0;
    end else begin
      if (w_overflow)               r_overflow <= 1'b1;
      if (w_collide || w_same_stage) r_collide  <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
  assign collide_o  = r_collide;

  // ---------------------------------------------------------------------------
  // Calibration comparator
  // ---------------------------------------------------------------------------
`ifdef GW2A_RDCAP_CALIB_EN
  // Even beats all-zero, odd beats all-ones.
  localparam logic [8*WIDTH-1:0] CalibPat = {4{{WIDTH{1'b1}}, {WIDTH{1'b0}}}};

  logic r_calib_pass;
  logic r_calib_fail;
  logic w_calib_match;

  // Compare the burst as it is pushed.
  always_comb begin
    w_calib_match = (w_burst == CalibPat);
  end

  // One-cycle result pulse, the cycle after the push.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_calib_pass <= 1'b0;
      r_calib_fail <= 1'b0;
    end else begin
      r_calib_pass <= w_push && w_calib_match;
      r_calib_fail <= w_push && !w_calib_match;
    end
  end

  assign calib_pass_o = r_calib_pass;
  assign calib_fail_o = r_calib_fail;
`else
  assign calib_pass_o = 1'b0;
  assign calib_fail_o = 1'b0;
`endif

endmodule
